// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with a one-entry load buffer and frame-aligned display update.
// Optional macro LEADING_ZERO_BLANK_EN additionally blanks leading zero digits (R is always shown).
module seg_scan_ctrl #(
  parameter int DIVIDE_BY = 100000
) (
  input  logic        clk,
  input  logic        btnC,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  input  logic [3:0]  load_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_done
);

  localparam int CNT_W = (DIVIDE_BY > 1) ? $clog2(DIVIDE_BY) : 1;
  localparam logic [CNT_W-1:0] DIV_MAX = CNT_W'(DIVIDE_BY - 1);

  typedef enum logic [1:0] {
    S_R  = 2'd0,
    S_RC = 2'd1,
    S_LC = 2'd2,
    S_L  = 2'd3
  } scan_state_t;

  scan_state_t      state;
  logic [CNT_W-1:0] div_cnt;
  logic             tick;
  logic             frame_end;
  logic             pend_full;
  logic [15:0]      pend_data;
  logic [3:0]       pend_mask;
  logic [15:0]      disp_data;
  logic [3:0]       disp_mask;
  logic [3:0]       show;
  logic [3:0]       nibble;
  logic             lit;

  assign tick       = (div_cnt == DIV_MAX);
  assign frame_end  = tick && (state == S_L);
  assign frame_done = frame_end;
  assign load_ready = !pend_full;

  always_ff @(posedge clk or posedge btnC) begin
    if (btnC) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Pending word is only promoted on the L->R tick, so the display never changes mid-frame.
  always_ff @(posedge clk or posedge btnC) begin
    if (btnC) begin
      state     <= S_R;
      pend_full <= 1'b0;
      pend_data <= 16'h0000;
      pend_mask <= 4'b0000;
      disp_data <= 16'h0000;
      disp_mask <= 4'b1111;
    end else begin
      if (tick) begin
        case (state)
          S_R:     state <= S_RC;
          S_RC:    state <= S_LC;
          S_LC:    state <= S_L;
          default: state <= S_R;
        endcase
      end
      if (frame_end && pend_full) begin
        disp_data <= pend_data;
        disp_mask <= pend_mask;
        pend_full <= 1'b0;
      end else if (load_valid && !pend_full) begin
        pend_data <= load_data;
        pend_mask <= load_mask;
        pend_full <= 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic zero_l;
  logic zero_lc;
  logic zero_rc;

  assign zero_l  = (disp_data[15:12] == 4'h0);
  assign zero_lc = zero_l  && (disp_data[11:8] == 4'h0);
  assign zero_rc = zero_lc && (disp_data[7:4]  == 4'h0);
  assign show    = disp_mask & ~{zero_l, zero_lc, zero_rc, 1'b0};
`else
  assign show = disp_mask;
`endif

  always_comb begin
    nibble = disp_data[{state, 2'b00} +: 4];
    lit    = show[state];
    an     = lit ? ~(4'b0001 << state) : 4'b1111;
    case (nibble)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    if (!lit) begin
      seg = 7'b1111111;
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter DIVIDE_BY, default 100000, SHALL set the clk cycles per digit slot; legal range 1 to 2^20.
REQ-002 Port clk  input  1  sole clock; all state SHALL change on its rising edge except reset.
REQ-003 Port btnC  input  1  reset, asynchronous, active-high.
REQ-004 Port load_valid  input  1  producer offers a new display word.
REQ-005 Port load_ready  output  1  controller can accept a word.
REQ-006 Port load_data  input  16  four hex nibbles: [3:0]=R, [7:4]=RC, [11:8]=LC, [15:12]=L.
REQ-007 Port load_mask  input  4  per-digit enable, same bit order as load_data; 1=shown.
REQ-008 Port an  output  4  anode select, active-low: R=an[0], RC=an[1], LC=an[2], L=an[3].
REQ-009 Port seg  output  7  cathodes GFEDCBA, active-low.
REQ-010 Port frame_done  output  1  one-cycle pulse at end of each scan frame.

Function
REQ-011 Divider counter SHALL count 0..DIVIDE_BY-1 and wrap; the wrap cycle SHALL be a tick; DIVIDE_BY=1 SHALL tick every cycle.
REQ-012 Scan FSM states SHALL be R, RC, LC, L; each tick SHALL advance R->RC->LC->L->R; no other transitions.
REQ-013 an SHALL be the one-hot-low pattern of the current state (1110, 1101, 1011, 0111) unless the slot is blanked, in which case an SHALL be 1111.
REQ-014 seg SHALL be the hex glyph of the current slot's display nibble: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110; blanked slot SHALL give 1111111.
REQ-015 an and seg SHALL be combinational from FSM state and display registers only; no path from load inputs.
REQ-016 A slot SHALL be blanked when its display mask bit is 0; a blanked slot SHALL still consume its full DIVIDE_BY cycles.
REQ-017 A transfer SHALL occur in a cycle with load_valid=1 and load_ready=1; data and mask SHALL be captured into a one-entry pending register.
REQ-018 load_ready SHALL be 1 exactly when the pending register is empty.
REQ-019 On the tick leaving state L, a full pending register SHALL be copied to the display registers and emptied; display SHALL never change mid-frame.
REQ-020 frame_done SHALL be 1 for exactly the tick cycle leaving state L.
REQ-021 A transfer in the same cycle as a frame boundary SHALL wait for the next boundary; pending cannot be full in that cycle, so no data is lost.
REQ-022 load_valid while load_ready=0 SHALL be ignored; the producer holds data until accepted.

Reset
REQ-023 btnC=1 SHALL immediately force: FSM=R, divider=0, pending empty, display data=16'h0000, display mask=4'b1111.
REQ-024 During and after reset: an=1110, seg=1000000, load_ready=1, frame_done=0.
REQ-025 Reset mid-frame SHALL discard any pending word; the first tick after release SHALL occur DIVIDE_BY cycles after the first active edge.

Configuration
REQ-026 Macro LEADING_ZERO_BLANK_EN, when defined, SHALL also blank any of L, LC, RC whose nibble is 0 and whose more-significant digits are all 0; R is never blanked for this reason.
REQ-027 Zero blanking SHALL be ANDed with the mask; without the macro, zeros display as 1000000 and only the mask blanks.

Verification (DIVIDE_BY=2)
REQ-028 Reset: btnC=1 -> an=1110, seg=1000000, load_ready=1; release, 8 clocks, no load -> an 1110,1101,1011,0111 per 2 clocks; frame_done pulses once per 8 clocks.
REQ-029 Load 16'hF5A3, mask 1111 in slot RC -> display unchanged to frame end, load_ready=0 until boundary+1; next frame seg 0110000, 0001000, 0010010, 0001110.
REQ-030 Mask 4'b0101 with 16'h1234 -> RC and L slots an=1111, seg=1111111; R shows 0011001 and LC shows 0100100.
REQ-031 Back-to-back loads 16'h1111 then 16'h2222 -> second held (ready=0) until boundary; frames show 1111 then 2222; no word lost.
REQ-032 Macro defined: 16'h0007 -> only R lit (1111000); 16'h0000 -> only R lit (1000000); 16'h0100 -> LC, RC, R lit. Undefined: all four lit.
REQ-033 btnC pulsed mid-frame with pending 16'hABCD -> an=1110 at once; load_ready=1; the following frames show 0000.
